// File: rtl/branch_metric_sched.sv
// Fano rate-1/2 branch-metric scheduler: issues both hypotheses to the shared hamming unit,
// converts the distances to signed metrics and returns them sorted. Option: BMS_ERRCNT_EN.
module branch_metric_sched #(
    parameter int unsigned M_BIAS = 1,
    parameter int unsigned M_PEN  = 5,
    parameter int unsigned MW     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_vld,
    output logic                 i_rdy,
    input  logic [1:0]           i_rx,
    input  logic [1:0]           i_c0,
    input  logic [1:0]           i_c1,
    input  logic [1:0]           i_mask,
    output logic                 hd_vld,
    output logic [1:0]           hd_mask,
    output logic [1:0]           hd_a,
    output logic [1:0]           hd_b,
    input  logic                 hd_o_vld,
    input  logic [1:0]           hd_metric,
`ifdef BMS_ERRCNT_EN
    output logic [15:0]          o_err_cnt,
`endif
    output logic                 o_vld,
    input  logic                 o_rdy,
    output logic                 o_best_bit,
    output logic signed [MW-1:0] o_m_best,
    output logic signed [MW-1:0] o_m_second,
    output logic [1:0]           o_d_best
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StIssue0 = 3'd1;
    localparam logic [2:0] StIssue1 = 3'd2;
    localparam logic [2:0] StWait   = 3'd3;
    localparam logic [2:0] StOut    = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [1:0]    hd_a_q, hd_a_d, hd_b_q, hd_b_d, hd_mask_q, hd_mask_d;
    logic [1:0]    c1_q, c1_d;
    logic          cnt_q, cnt_d;
    logic [1:0]    d0_q, d0_d;
    logic          best_bit_q, best_bit_d;
    logic [MW-1:0] m_best_q, m_best_d, m_second_q, m_second_d;
    logic [1:0]    d_best_q, d_best_d;
    logic [1:0]    nb;
    logic [MW-1:0] m0, m1;

    // Wraps in MW bits by design; MW is sized to hold the full metric range.
    function automatic logic [MW-1:0] metric(input logic [1:0] n, input logic [1:0] d);
        return MW'(M_BIAS * 32'(n)) - MW'(M_PEN * 32'(d));
    endfunction

    // hd_mask_q keeps the request mask until the next accept.
    assign nb = 2'(hd_mask_q[0]) + 2'(hd_mask_q[1]);
    assign m0 = metric(nb, d0_q);
    assign m1 = metric(nb, hd_metric);

    always_comb begin
        state_d    = state_q;
        hd_a_d     = hd_a_q;
        hd_b_d     = hd_b_q;
        hd_mask_d  = hd_mask_q;
        c1_d       = c1_q;
        cnt_d      = cnt_q;
        d0_d       = d0_q;
        best_bit_d = best_bit_q;
        m_best_d   = m_best_q;
        m_second_d = m_second_q;
        d_best_d   = d_best_q;
        case (state_q)
            StIdle: begin
                if (i_vld) begin
                    state_d   = StIssue0;
                    hd_a_d    = i_rx;
                    hd_b_d    = i_c0;
                    hd_mask_d = i_mask;
                    c1_d      = i_c1;
                    cnt_d     = 1'b0;
                end
            end
            StIssue0: begin
                state_d = StIssue1;
                hd_b_d  = c1_q;
            end
            StIssue1: begin
                state_d = StWait;
                if (hd_o_vld) begin
                    d0_d  = hd_metric;
                    cnt_d = 1'b1;
                end
            end
            StWait: begin
                if (hd_o_vld) begin
                    if (!cnt_q) begin
                        d0_d  = hd_metric;
                        cnt_d = 1'b1;
                    end else begin
                        state_d = StOut;
                        cnt_d   = 1'b0;
                        // Strict compare: ties resolve to info bit 0.
                        if (hd_metric < d0_q) begin
                            best_bit_d = 1'b1;
                            m_best_d   = m1;
                            m_second_d = m0;
                            d_best_d   = hd_metric;
                        end else begin
                            best_bit_d = 1'b0;
                            m_best_d   = m0;
                            m_second_d = m1;
                            d_best_d   = d0_q;
                        end
                    end
                end
            end
            StOut: begin
                if (o_rdy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            hd_a_q     <= '0;
            hd_b_q     <= '0;
            hd_mask_q  <= '0;
            c1_q       <= '0;
            cnt_q      <= 1'b0;
            d0_q       <= '0;
            best_bit_q <= 1'b0;
            m_best_q   <= '0;
            m_second_q <= '0;
            d_best_q   <= '0;
        end else begin
            state_q    <= state_d;
            hd_a_q     <= hd_a_d;
            hd_b_q     <= hd_b_d;
            hd_mask_q  <= hd_mask_d;
            c1_q       <= c1_d;
            cnt_q      <= cnt_d;
            d0_q       <= d0_d;
            best_bit_q <= best_bit_d;
            m_best_q   <= m_best_d;
            m_second_q <= m_second_d;
            d_best_q   <= d_best_d;
        end
    end

`ifdef BMS_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [16:0] err_sum;

    assign err_sum = {1'b0, err_cnt_q} + 17'(d_best_q);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (state_q == StOut && o_rdy) begin
            err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) err_cnt_q <= '0;
        else          err_cnt_q <= err_cnt_d;
    end

    assign o_err_cnt = err_cnt_q;
`endif

    assign i_rdy      = (state_q == StIdle);
    assign hd_vld     = (state_q == StIssue0) || (state_q == StIssue1);
    assign hd_a       = hd_a_q;
    assign hd_b       = hd_b_q;
    assign hd_mask    = hd_mask_q;
    assign o_vld      = (state_q == StOut);
    assign o_best_bit = best_bit_q;
    assign o_m_best   = m_best_q;
    assign o_m_second = m_second_q;
    assign o_d_best   = d_best_q;

endmodule
